// File: rtl/radius_pipe.sv
// Fully pipelined floor(sqrt(x^2+y^2)) with radial band and sideband, 13 enabled cycles of latency.
// No backpressure: i_ce low freezes every stage, otherwise one sample per clock.
module radius_pipe #(
  parameter int BAND_SHIFT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_ce,
  input  logic       i_valid,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic [2:0] i_side,
  output logic       o_valid,
  output logic [9:0] o_r_sqrt,
  output logic [3:0] o_band,
  output logic [2:0] o_side
);

  localparam int NSQ = 10;
  localparam int NSTG = 13;

  logic [9:0]  ax_q, ay_q;
  logic [19:0] sx_q, sy_q;
  logic [19:0] sum_q;

  logic [9:0]  root_q [NSQ];
  logic [20:0] rem_q  [NSQ];
  logic [19:0] rad_q  [NSQ];
  logic [9:0]  root_d [NSQ];
  logic [20:0] rem_d  [NSQ];
  logic [19:0] rad_d  [NSQ];

  logic [NSTG-1:0]      vld_q;
  logic [NSTG-1:0][2:0] side_q;

  // Restoring square root: each stage brings in two radicand bits and decides one root bit.
  for (genvar k = 0; k < NSQ; k++) begin : g_sqrt
    logic [9:0]  root_in;
    logic [20:0] rem_in;
    logic [19:0] rad_in;
    logic [22:0] rem_sh;
    logic [22:0] trial;
    logic        fit;

    if (k == 0) begin : g_first
      assign root_in = '0;
      assign rem_in  = '0;
      assign rad_in  = sum_q;
    end else begin : g_next
      assign root_in = root_q[k-1];
      assign rem_in  = rem_q[k-1];
      assign rad_in  = rad_q[k-1];
    end

    assign rem_sh    = {rem_in, rad_in[19:18]};
    assign trial     = {11'd0, root_in, 2'b01};
    assign fit       = (rem_sh >= trial);
    assign root_d[k] = {root_in[8:0], fit};
    assign rem_d[k]  = fit ? 21'(rem_sh - trial) : rem_sh[20:0];
    assign rad_d[k]  = {rad_in[17:0], 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ax_q   <= '0;
      ay_q   <= '0;
      sx_q   <= '0;
      sy_q   <= '0;
      sum_q  <= '0;
      vld_q  <= '0;
      side_q <= '0;
      for (int k = 0; k < NSQ; k++) begin
        root_q[k] <= '0;
        rem_q[k]  <= '0;
        rad_q[k]  <= '0;
      end
    end else if (i_ce) begin
      // |-512| = 512 still fits the 10-bit unsigned magnitude
      ax_q   <= i_x[9] ? (~i_x + 10'd1) : i_x;
      ay_q   <= i_y[9] ? (~i_y + 10'd1) : i_y;
      sx_q   <= {10'd0, ax_q} * {10'd0, ax_q};
      sy_q   <= {10'd0, ay_q} * {10'd0, ay_q};
      sum_q  <= sx_q + sy_q;
      vld_q  <= {vld_q[NSTG-2:0], i_valid};
      side_q <= {side_q[NSTG-2:0], i_side};
      for (int k = 0; k < NSQ; k++) begin
        root_q[k] <= root_d[k];
        rem_q[k]  <= rem_d[k];
        rad_q[k]  <= rad_d[k];
      end
    end
  end

  // The final remainder and exhausted radicand are kept for stage uniformity only.
  logic unused_tail;
  assign unused_tail = ^{rem_q[NSQ-1], rad_q[NSQ-1]};

  assign o_valid  = vld_q[NSTG-1];
  assign o_side   = side_q[NSTG-1];
  assign o_r_sqrt = root_q[NSQ-1];
  assign o_band   = root_q[NSQ-1][BAND_SHIFT+3:BAND_SHIFT];

endmodule

// File: tb/tb_radius_pipe.sv
// Randomised and directed bench for radius_pipe against a history-queue reference model.
module tb_radius_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_ce;
  logic       i_valid;
  logic [9:0] i_x;
  logic [9:0] i_y;
  logic [2:0] i_side;
  logic       o_valid;
  logic [9:0] o_r_sqrt;
  logic [3:0] o_band;
  logic [2:0] o_side;

  radius_pipe #(.BAND_SHIFT(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_ce     (i_ce),
    .i_valid  (i_valid),
    .i_x      (i_x),
    .i_y      (i_y),
    .i_side   (i_side),
    .o_valid  (o_valid),
    .o_r_sqrt (o_r_sqrt),
    .o_band   (o_band),
    .o_side   (o_side)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       v;
    bit [2:0] s;
    int       r;
  } rec_t;

  rec_t hist[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int isqrt(input int n);
    int r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  // One clock: drive, capture, then compare against the sample taken 13 enabled edges ago.
  task automatic tick(input bit ce, input bit v, input logic [9:0] x, input logic [9:0] y,
                      input logic [2:0] s, input int gold);
    rec_t nr;
    rec_t e;
    int   sx, sy;
    i_ce    = ce;
    i_valid = v;
    i_x     = x;
    i_y     = y;
    i_side  = s;
    @(posedge clk);
    if (ce) begin
      sx   = int'($signed(x));
      sy   = int'($signed(y));
      nr.v = v;
      nr.s = s;
      nr.r = (gold >= 0) ? gold : isqrt(sx * sx + sy * sy);
      hist.push_back(nr);
    end
    @(negedge clk);
    if (hist.size() >= 13) e = hist[hist.size() - 13];
    else begin
      e.v = 1'b0;
      e.s = 3'd0;
      e.r = 0;
    end
    chk("valid",  int'(o_valid),  int'(e.v));
    chk("r_sqrt", int'(o_r_sqrt), e.r);
    chk("band",   int'(o_band),   (e.r >> 3) & 15);
    chk("side",   int'(o_side),   int'(e.s));
  endtask

  task automatic rnd_tick(input bit ce, input bit v, input logic [2:0] s);
    tick(ce, v, 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)), s, -1);
  endtask

  int dx[6] = '{3, -512, 511, -323, 0, 1};
  int dy[6] = '{4, -512, -512, -243, 0, 1};
  int dr[6] = '{5, 724, 723, 404, 0, 1};

  initial begin
    rst_n   = 1'b0;
    i_ce    = 1'b1;
    i_valid = 1'b0;
    i_x     = '0;
    i_y     = '0;
    i_side  = '0;
    #2;
    chk("rst_valid",  int'(o_valid),  0);
    chk("rst_r_sqrt", int'(o_r_sqrt), 0);
    chk("rst_band",   int'(o_band),   0);
    chk("rst_side",   int'(o_side),   0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed corners with hand-derived roots
    for (int i = 0; i < 6; i++)
      tick(1'b1, 1'b1, 10'(dx[i]), 10'(dy[i]), 3'(i + 1), dr[i]);
    for (int i = 0; i < 13; i++) tick(1'b1, 1'b0, 10'd0, 10'd0, 3'd0, -1);

    // back-to-back random stream with index-tagged sideband
    for (int i = 0; i < 100; i++) rnd_tick(1'b1, 1'b1, 3'(i));

    // clock-enable gap mid-flight; garbage on inputs must not be captured
    for (int i = 0; i < 5; i++) rnd_tick(1'b1, 1'b1, 3'(i + 3));
    for (int i = 0; i < 7; i++) rnd_tick(1'b0, 1'b1, 3'd7);
    for (int i = 0; i < 15; i++) rnd_tick(1'b1, ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)));

    // asynchronous reset with samples in flight
    for (int i = 0; i < 10; i++) rnd_tick(1'b1, 1'b1, 3'b111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid",  int'(o_valid),  0);
    chk("arst_r_sqrt", int'(o_r_sqrt), 0);
    chk("arst_side",   int'(o_side),   0);
    @(negedge clk);
    rst_n = 1'b1;
    hist.delete();
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 10'd0, 10'd0, 3'd0, -1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
